shift_ring_register: RTL and testbench
======================================

# shift_ring_register

Parametrised, multi-mode shift/ring register with a counted-step run controller. It generalises the fixed 5-stage JK shift chain with OR feedback into one register of configurable width. The register supports serial, OR-feedback, ring, Johnson and parallel-load modes in either direction, and each operation runs for a requested number of steps with a busy/done handshake. It is used as a sequence/pattern generator and as a serialiser in lab datapaths.

## Interface
- WIDTH, 5, register length (≥2)
- CNT_W, 8, width of the step count

- clk  in  1  rising-edge clock
- clear  in  1  reset: synchronous, active-low (0 clears on the next rising edge of clk)
- preset  in  1  synchronous, active-high; sets q to all ones; honoured only in IDLE
- start  in  1  request; sampled only in IDLE
- mode  in  3  0 HOLD, 1 SERIAL, 2 SERIAL_OR, 3 RING, 4 JOHNSON, 5 LOAD, 6/7 reserved (treated as HOLD)
- dir  in  1  0 = shift toward MSB (insert at q[0]); 1 = toward LSB (insert at q[WIDTH-1])
- steps  in  CNT_W  number of shifts to perform
- serial_in  in  1  insert bit for SERIAL/SERIAL_OR; sampled every shift cycle
- load_data  in  WIDTH  parallel value for LOAD
- q  out  WIDTH  register contents
- serial_out  out  1  outgoing bit: q[WIDTH-1] if dir_r=0, else q[0]
- busy  out  1  high while in RUN
- done  out  1  one-cycle completion pulse

## Operation
- Outgoing bit o: q[WIDTH-1] (dir 0) or q[0] (dir 1). The inserted bit per mode:
  - SERIAL: serial_in
  - SERIAL_OR: serial_in | o
  - RING: o
  - JOHNSON: ~o
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - Latch mode_r, dir_r.
  - LOAD: q ← load_data, go to DONE.
  - HOLD/reserved or steps=0: q unchanged, go to DONE.
  - Otherwise: perform the first shift on the same edge. If steps=1, go to DONE; else remaining ← steps−1 and go to RUN.
- RUN: one shift per cycle using mode_r/dir_r. remaining decrements. When remaining=1, perform the final shift and go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Ignored inputs:
  - start while in RUN/DONE is ignored (not queued).
  - mode, dir and steps changes during RUN are ignored.
- Priority on any edge: clear > preset > start. preset together with start in IDLE applies preset only; start is dropped.
- Arithmetic: remaining is CNT_W bits, no wrap. steps = 2^CNT_W−1 performs exactly that many shifts.

## Timing
- Reset (clear=0 at an edge): q=0, state IDLE, remaining=0, dir_r=0, mode_r=HOLD, busy=0, done=0, serial_out=0.
- Start sampled at edge E0 with steps=N≥1: shifts occur at E0…E(N−1).
  - busy=1 after E0 through E(N−1) when N≥2.
  - done=1 in the cycle after E(N−1).
  - Earliest next start is sampled at E(N+1).
- LOAD, steps=0, HOLD: done=1 in the cycle after E0; busy stays 0.
- clear mid-RUN: on that edge, q=0, IDLE, busy=0, no done pulse.
- serial_in is sampled at each shift edge. serial_out reflects registered q (no combinational path from inputs).

## Structure
- Package shift_ring_pkg holds:
  - mode encodings (MODE_HOLD…MODE_LOAD)
  - FSM state encoding
  - dir constants
- Sub-module shift_ring_step: combinational next-vector computation from (q, mode, dir, serial_in). The top level holds the FSM, counter and registers.

## Test plan
- Reset: clear=0 for one edge with random inputs → q=00000, busy=0, done=0, serial_out=0.
- JOHNSON, WIDTH=5, dir=0, from q=00000, steps=10 → q goes 00001, 00011, 00111, 01111, 11111, 11110, 11100, 11000, 10000, 00000. done is one cycle after the 10th shift; busy is high for cycles 1–9.
- SERIAL_OR, dir=0, from 0, steps=6, serial_in=1 on the first shift only → q after 5 shifts = 10000, after 6 shifts = 00001. Output feedback recirculates.
- LOAD 10110, then RING dir=1 with steps=3 → q is 10110 one cycle after load, then 01011, 10101, 11010.
- steps=20 SERIAL; start re-asserted at shift 2; clear=0 at shift 3 → the re-start is ignored; after the clear edge q=0, busy=0, and done never pulses.
- steps=0 SERIAL, then mode=7 with steps=4 → q is unchanged both times. done pulses one cycle after each start; busy stays 0. preset together with start in IDLE → q=11111 and no run.

Source files
------------

// File: rtl/shift_ring_pkg.sv
// Shared encodings for the shift/ring register: operating modes, run-controller
// states and shift-direction constants.
package shift_ring_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD      = 3'd0,
    MODE_SERIAL    = 3'd1,
    MODE_SERIAL_OR = 3'd2,
    MODE_RING      = 3'd3,
    MODE_JOHNSON   = 3'd4,
    MODE_LOAD      = 3'd5
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic DIR_TO_MSB = 1'b0;
  localparam logic DIR_TO_LSB = 1'b1;

  // Only these modes move bits; LOAD, HOLD and the reserved codes finish at once.
  function automatic logic is_shift_mode(input logic [2:0] m);
    logic res;
    case (m)
      MODE_SERIAL, MODE_SERIAL_OR, MODE_RING, MODE_JOHNSON: res = 1'b1;
      default:                                              res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/shift_ring_step.sv
// Combinational next-vector for one shift step, given the current register,
// mode, direction and serial input.
module shift_ring_step
  import shift_ring_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             dir,
  input  logic             serial_in,
  output logic [WIDTH-1:0] next_q
);

  logic out_bit;
  logic ins_bit;

  // Select the outgoing bit, form the inserted bit and shift it in.
  always_comb begin
    out_bit = 1'b0;
    ins_bit = 1'b0;
    next_q  = q;

    if (dir == DIR_TO_LSB) begin
      out_bit = q[0];
    end else begin
      out_bit = q[WIDTH-1];
    end

    case (mode)
      MODE_SERIAL:    ins_bit = serial_in;
      MODE_SERIAL_OR: ins_bit = serial_in | out_bit;
      MODE_RING:      ins_bit = out_bit;
      MODE_JOHNSON:   ins_bit = ~out_bit;
      default:        ins_bit = 1'b0;
    endcase

    if (!is_shift_mode(mode)) begin
      next_q = q;
    end else if (dir == DIR_TO_LSB) begin
      next_q = {ins_bit, q[WIDTH-1:1]};
    end else begin
      next_q = {q[WIDTH-2:0], ins_bit};
    end
  end

endmodule

// File: rtl/shift_ring_register.sv
// Multi-mode shift/ring register with a counted-step run controller and a
// busy/done handshake.
module shift_ring_register
  import shift_ring_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             preset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic             dir,
  input  logic [CNT_W-1:0] steps,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] Q_ONES   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] Q_ZERO   = {WIDTH{1'b0}};

  state_e           state_r;
  mode_e            mode_r;
  logic             dir_r;
  logic [CNT_W-1:0] remaining_r;
  logic [WIDTH-1:0] q_r;
  logic             busy_r;
  logic             done_r;

  logic [2:0]       step_mode_s;
  logic             step_dir_s;
  logic [WIDTH-1:0] step_next_s;

  // The first shift happens on the start edge, so IDLE uses the live inputs.
  always_comb begin
    if (state_r == ST_IDLE) begin
      step_mode_s = mode;
      step_dir_s  = dir;
    end else begin
      step_mode_s = mode_r;
      step_dir_s  = dir_r;
    end
  end

  shift_ring_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .q        (q_r),
    .mode     (step_mode_s),
    .dir      (step_dir_s),
    .serial_in(serial_in),
    .next_q   (step_next_s)
  );

  // Run controller: state, step counter, latched mode/dir and register contents.
  always_ff @(posedge clk) begin
    if (!clear) begin
      state_r     <= ST_IDLE;
      mode_r      <= MODE_HOLD;
      dir_r       <= DIR_TO_MSB;
      remaining_r <= CNT_ZERO;
      q_r         <= Q_ZERO;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          if (preset) begin
            q_r <= Q_ONES;
          end else if (start) begin
            mode_r <= mode_e'(mode);
            dir_r  <= dir;
            if (mode == MODE_LOAD) begin
              q_r     <= load_data;
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else if (is_shift_mode(mode) && (steps != CNT_ZERO)) begin
              q_r <= step_next_s;
              if (steps == CNT_ONE) begin
                state_r <= ST_DONE;
                done_r  <= 1'b1;
              end else begin
                remaining_r <= steps - CNT_ONE;
                state_r     <= ST_RUN;
                busy_r      <= 1'b1;
              end
            end else begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_RUN: begin
          q_r <= step_next_s;
          if (remaining_r == CNT_ONE) begin
            remaining_r <= CNT_ZERO;
            state_r     <= ST_DONE;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
          end else begin
            remaining_r <= remaining_r - CNT_ONE;
          end
        end

        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign q          = q_r;
  assign busy       = busy_r;
  assign done       = done_r;
  // Derived purely from registered state, so no input reaches it combinationally.
  assign serial_out = (dir_r == DIR_TO_LSB) ? q_r[0] : q_r[WIDTH-1];

endmodule

// File: tb/tb_shift_ring_register.sv
// Directed bench for shift_ring_register with hand-computed expected values.
module tb_shift_ring_register;

  logic       clk = 1'b0;
  logic       clear;
  logic       preset;
  logic       start;
  logic [2:0] mode;
  logic       dir;
  logic [7:0] steps;
  logic       serial_in;
  logic [4:0] load_data;
  logic [4:0] q;
  logic       serial_out;
  logic       busy;
  logic       done;

  int checks_total = 0;
  int checks_passed = 0;

  shift_ring_register #(.WIDTH(5), .CNT_W(8)) dut (
    .clk       (clk),
    .clear     (clear),
    .preset    (preset),
    .start     (start),
    .mode      (mode),
    .dir       (dir),
    .steps     (steps),
    .serial_in (serial_in),
    .load_data (load_data),
    .q         (q),
    .serial_out(serial_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      checks_passed++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] johnson_seq [10];
  int cnt;

  initial begin
    johnson_seq = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111,
                    5'b11110, 5'b11100, 5'b11000, 5'b10000, 5'b00000};

    // Reset with random inputs.
    clear = 1'b0; preset = 1'($urandom); start = 1'($urandom);
    mode = 3'($urandom); dir = 1'($urandom); steps = 8'($urandom);
    serial_in = 1'($urandom); load_data = 5'($urandom);
    #2;
    tick();
    check_val("reset_q", 32'(q), 32'h0);
    check_val("reset_busy", 32'(busy), 32'h0);
    check_val("reset_done", 32'(done), 32'h0);
    check_val("reset_so", 32'(serial_out), 32'h0);
    clear = 1'b1; preset = 1'b0; start = 1'b0; serial_in = 1'b0;
    tick();

    // JOHNSON, dir 0, 10 steps from zero.
    mode = 3'd4; dir = 1'b0; steps = 8'd10; start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      start = 1'b0;
      check_val($sformatf("john_q%0d", i), 32'(q), 32'(johnson_seq[i]));
      check_val($sformatf("john_so%0d", i), 32'(serial_out), 32'(johnson_seq[i][4]));
      check_val($sformatf("john_busy%0d", i), 32'(busy), (i < 9) ? 32'h1 : 32'h0);
      check_val($sformatf("john_done%0d", i), 32'(done), (i == 9) ? 32'h1 : 32'h0);
    end
    tick();
    check_val("john_done_after", 32'(done), 32'h0);

    // SERIAL_OR, dir 0, 6 steps, serial_in only on the first shift.
    mode = 3'd2; dir = 1'b0; steps = 8'd6; serial_in = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; serial_in = 1'b0;
    check_val("sor_q1", 32'(q), 32'b00001);
    for (int i = 2; i <= 5; i++) tick();
    check_val("sor_q5", 32'(q), 32'b10000);
    tick();
    check_val("sor_q6", 32'(q), 32'b00001);
    check_val("sor_done", 32'(done), 32'h1);
    tick();

    // LOAD then RING toward LSB for 3 steps.
    mode = 3'd5; load_data = 5'b10110; start = 1'b1;
    tick();
    start = 1'b0;
    check_val("load_q", 32'(q), 32'b10110);
    check_val("load_done", 32'(done), 32'h1);
    check_val("load_busy", 32'(busy), 32'h0);
    tick();
    mode = 3'd3; dir = 1'b1; steps = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check_val("ring_q1", 32'(q), 32'b01011);
    check_val("ring_so1", 32'(serial_out), 32'h1);
    tick();
    check_val("ring_q2", 32'(q), 32'b10101);
    tick();
    check_val("ring_q3", 32'(q), 32'b11010);
    check_val("ring_done", 32'(done), 32'h1);
    tick();

    // Long SERIAL run with ignored restart, then clear mid-run.
    mode = 3'd1; dir = 1'b0; steps = 8'd20; serial_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; mode = 3'd5; load_data = 5'b01110;
    tick();
    check_val("ser_q3", 32'(q), 32'b10000);
    check_val("ser_busy3", 32'(busy), 32'h1);
    clear = 1'b0;
    tick();
    clear = 1'b1; start = 1'b0;
    check_val("clr_q", 32'(q), 32'h0);
    check_val("clr_busy", 32'(busy), 32'h0);
    check_val("clr_done", 32'(done), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val($sformatf("clr_nodone%0d", i), 32'(done), 32'h0);
      check_val($sformatf("clr_q%0d", i), 32'(q), 32'h0);
    end

    // preset with start in IDLE: preset only, no run.
    preset = 1'b1; start = 1'b1; mode = 3'd1; steps = 8'd5;
    tick();
    preset = 1'b0; start = 1'b0;
    check_val("preset_q", 32'(q), 32'b11111);
    check_val("preset_busy", 32'(busy), 32'h0);
    check_val("preset_done", 32'(done), 32'h0);
    tick();
    check_val("preset_done2", 32'(done), 32'h0);

    // steps=0 SERIAL, then reserved mode 7 with 4 steps.
    mode = 3'd1; steps = 8'd0; serial_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check_val("zero_q", 32'(q), 32'b11111);
    check_val("zero_done", 32'(done), 32'h1);
    check_val("zero_busy", 32'(busy), 32'h0);
    tick();
    check_val("zero_done_off", 32'(done), 32'h0);
    mode = 3'd7; steps = 8'd4; start = 1'b1;
    tick();
    start = 1'b0;
    check_val("rsv_q", 32'(q), 32'b11111);
    check_val("rsv_done", 32'(done), 32'h1);
    check_val("rsv_busy", 32'(busy), 32'h0);
    tick();
    check_val("rsv_q2", 32'(q), 32'b11111);

    // Maximum step count: JOHNSON 255 shifts from zero ends at 11111.
    clear = 1'b0;
    tick();
    clear = 1'b1;
    mode = 3'd4; dir = 1'b0; steps = 8'd255; start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 1;
    while (!done && cnt < 400) begin
      tick();
      cnt++;
    end
    check_val("max_cycles", 32'(cnt), 32'd255);
    check_val("max_q", 32'(q), 32'b11111);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
